sprite_line_fetch: RTL and testbench
====================================

SPRITE_LINE_FETCH -- requirements
Module: sprite_line_fetch

Interface
REQ-001 SHALL have parameter SPR_W, default 20, sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 20, sprite height in pixels; SPR_W*SPR_H SHALL be at most 512.
REQ-003 SHALL have parameter KEY_COLOR, default 8'd0, the RGB332 value treated as transparent.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port line_start, input, 1, a one-cycle pulse at the start of hblank that requests a fetch for the next line.
REQ-007 SHALL have port next_y, input, 10, the screen row being prepared, sampled on line_start.
REQ-008 SHALL have ports spr_x and spr_y, input, 10 each, the sprite top-left position, sampled on line_start.
REQ-009 SHALL have port rom_addr, output, 9, registered address to the sprite ROM.
REQ-010 SHALL have port rom_q, input, 8, ROM data, valid one cycle after rom_addr.
REQ-011 SHALL have ports pix_x (input, 10) and pix_valid (input, 1), the current active-video column and its qualifier.
REQ-012 SHALL have port pix_out, output, 8, the RGB332 sprite pixel.
REQ-013 SHALL have port pix_hit, output, 1, high when an opaque sprite pixel is present.
REQ-014 SHALL have port busy, output, 1, high while a fetch is in progress.

Function
REQ-015 SHALL implement the states IDLE, FETCH and LAST; line_valid is an internal flag.
REQ-016 On line_start, SHALL compute row = next_y - spr_y modulo 2^10 and latch spr_x.
REQ-017 If row < SPR_H, SHALL clear line_valid and enter FETCH; otherwise SHALL clear line_valid and stay in or return to IDLE.
REQ-018 In FETCH, SHALL drive rom_addr = row*SPR_W + c for c = 0..SPR_W-1, one per cycle, beginning the cycle after line_start.
REQ-019 Each rom_q value SHALL be written into line buffer entry c one cycle after its address is driven.
REQ-020 After address SPR_W-1, SHALL enter LAST for one cycle to capture the final pixel, then set line_valid and go to IDLE.
REQ-021 busy SHALL be high for exactly SPR_W+1 cycles per fetch.
REQ-022 A line_start during FETCH or LAST SHALL abort the current fetch and restart per REQ-016/017; no stale write SHALL land after the restart.
REQ-023 Display path: col = pix_x - spr_x_latched modulo 2^10.
REQ-024 hit = pix_valid & line_valid & (col < SPR_W) & (buffer[col] != KEY_COLOR).
REQ-025 pix_hit and pix_out SHALL be registered with 1-cycle latency from pix_x; pix_out = buffer[col] when hit, else 0.
REQ-026 Line buffer SHALL be SPR_W x 8 registers; a fetch and the display SHALL never overlap within one line.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, line_valid 0, rom_addr 0, pix_out 0, pix_hit 0 and busy 0; line buffer contents are not reset.
REQ-028 A reset during FETCH SHALL discard the fetch; no hit SHALL occur until a complete fetch finishes.

Configuration
REQ-029 With SPRITE_MIRROR_EN defined, SHALL add port face_left (input, 1), sampled on line_start; when it is 1, buffer entry c SHALL receive rom[row*SPR_W + SPR_W-1-c].
REQ-030 Without SPRITE_MIRROR_EN, face_left SHALL be absent and the fetch order SHALL always be unmirrored.

Verification
REQ-031 spr_y=100, next_y=103, line_start: rom_addr 60..79 on the 20 following cycles, busy high for 21 cycles, then line_valid is set.
REQ-032 spr_x=200, pix_x sweep 0..639 after a valid fetch: pix_hit high for pix_x 200..219 (excluding KEY_COLOR pixels) one cycle later, pix_out equals ROM row data, and pix_hit is 0 at 199 and 220.
REQ-033 next_y=99, spr_y=100: no ROM access, busy stays 0, and pix_hit is 0 for the whole line; spr_x=630: hits only for pix_x 630..639.
REQ-034 Second line_start on cycle 10 of a fetch: rom_addr restarts at the new row base and the buffer holds only the new row.
REQ-035 rst_n low mid-fetch: all outputs are 0 immediately, and there is no hit until the next full fetch.
REQ-036 With SPRITE_MIRROR_EN, face_left=1, row 0: pix_out at spr_x equals rom[19] and at spr_x+19 equals rom[0].

Source files
------------

// File: rtl/sprite_line_fetch.sv
// Sprite line fetcher: during hblank, copies one row of a sprite from ROM
// into a small line buffer, then overlays it on the next active line.
// Optional build macro: SPRITE_MIRROR_EN adds the face_left input, which
// fills the line buffer in reverse column order.
module sprite_line_fetch #(
    parameter int         SPR_W     = 20,
    parameter int         SPR_H     = 20,
    parameter logic [7:0] KEY_COLOR = 8'd0
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       line_start,
    input  logic [9:0] next_y,
    input  logic [9:0] spr_x,
    input  logic [9:0] spr_y,
`ifdef SPRITE_MIRROR_EN
    input  logic       face_left,
`endif
    output logic [8:0] rom_addr,
    input  logic [7:0] rom_q,
    input  logic [9:0] pix_x,
    input  logic       pix_valid,
    output logic [7:0] pix_out,
    output logic       pix_hit,
    output logic       busy
);
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, LAST} state_t;

    state_t        state, state_next;
    logic [CW-1:0] col_cnt, col_next, fetch_idx;
    logic [8:0]    base_in, base_lat, base_sel, rom_addr_next;
    logic          mirror_in, mirror_lat, mirror_sel;
    logic [9:0]    row_in, spr_x_lat, disp_col;
    logic          row_ok, line_valid;
    logic [7:0]    line_buf [SPR_W];
    logic          buf_we;
    logic [CW-1:0] buf_widx;
    logic          disp_in_range, disp_hit;
    logic [7:0]    disp_pix;

`ifdef SPRITE_MIRROR_EN
    assign mirror_in = face_left;
`else
    assign mirror_in = 1'b0;
`endif

    // Row within the sprite wraps modulo 2^10, so rows above the sprite look huge and fail the bound.
    assign row_in  = next_y - spr_y;
    assign row_ok  = row_in < 10'(SPR_H);
    assign base_in = 9'(32'(row_in) * SPR_W);
    assign busy    = (state != IDLE);

    // Next-state and next-address logic; a line_start always wins and restarts from column 0.
    always_comb begin
        state_next    = state;
        col_next      = col_cnt;
        base_sel      = line_start ? base_in : base_lat;
        mirror_sel    = line_start ? mirror_in : mirror_lat;
        rom_addr_next = rom_addr;
        if (line_start) begin
            col_next   = '0;
            state_next = row_ok ? FETCH : IDLE;
        end else begin
            case (state)
                FETCH: begin
                    if (col_cnt == CW'(SPR_W - 1)) begin
                        state_next = LAST;
                    end else begin
                        col_next = col_cnt + CW'(1);
                    end
                end
                LAST:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
        fetch_idx = mirror_sel ? (CW'(SPR_W - 1) - col_next) : col_next;
        if (state_next == FETCH) begin
            rom_addr_next = base_sel + 9'(fetch_idx);
        end
    end

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch datapath registers plus the line_valid flag that gates the display.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt    <= '0;
            rom_addr   <= '0;
            base_lat   <= '0;
            mirror_lat <= 1'b0;
            spr_x_lat  <= '0;
            line_valid <= 1'b0;
        end else begin
            col_cnt  <= col_next;
            rom_addr <= rom_addr_next;
            if (line_start) begin
                base_lat   <= base_in;
                mirror_lat <= mirror_in;
                spr_x_lat  <= spr_x;
                line_valid <= 1'b0;
            end else if (state == LAST) begin
                line_valid <= 1'b1;
            end
        end
    end

    // ROM data trails its address by a cycle; a restart suppresses the in-flight write.
    always_comb begin
        buf_we   = 1'b0;
        buf_widx = col_cnt - CW'(1);
        if (!line_start) begin
            if (state == FETCH && col_cnt != '0) begin
                buf_we = 1'b1;
            end else if (state == LAST) begin
                buf_we   = 1'b1;
                buf_widx = CW'(SPR_W - 1);
            end
        end
    end

    // Line buffer storage; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            line_buf[buf_widx] <= rom_q;
        end
    end

    assign disp_col      = pix_x - spr_x_lat;
    assign disp_in_range = disp_col < 10'(SPR_W);

    // Buffer lookup for the current column, zero outside the sprite.
    always_comb begin
        disp_pix = disp_in_range ? line_buf[disp_col[CW-1:0]] : 8'd0;
        disp_hit = pix_valid & line_valid & disp_in_range & (disp_pix != KEY_COLOR);
    end

    // Registered overlay outputs, one cycle behind pix_x.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pix_hit <= 1'b0;
            pix_out <= 8'd0;
        end else begin
            pix_hit <= disp_hit;
            pix_out <= disp_hit ? disp_pix : 8'd0;
        end
    end
endmodule

// File: tb/tb_sprite_line_fetch.sv
// Self-checking bench for sprite_line_fetch with a behavioural ROM/overlay model.
`timescale 1ns/1ps
module tb_sprite_line_fetch;
    localparam int         W   = 20;
    localparam int         H   = 20;
    localparam logic [7:0] KEY = 8'd0;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       line_start = 1'b0;
    logic [9:0] next_y = '0, spr_x = '0, spr_y = '0, pix_x = '0;
    logic       pix_valid = 1'b0;
    logic [8:0] rom_addr;
    logic [7:0] rom_q = '0;
    logic [7:0] pix_out;
    logic       pix_hit, busy;
`ifdef SPRITE_MIRROR_EN
    logic       face_left = 1'b0;
`endif

    logic [7:0] rom [512];
    int vectors = 0;
    int miscompares = 0;
    int mRow = 0;
    int mSx = 0;
    bit mMir = 1'b0;
    bit mValid = 1'b0;

    sprite_line_fetch #(.SPR_W(W), .SPR_H(H), .KEY_COLOR(KEY)) dut (
        .clock(clock),
        .rst_n(rst_n),
        .line_start(line_start),
        .next_y(next_y),
        .spr_x(spr_x),
        .spr_y(spr_y),
`ifdef SPRITE_MIRROR_EN
        .face_left(face_left),
`endif
        .rom_addr(rom_addr),
        .rom_q(rom_q),
        .pix_x(pix_x),
        .pix_valid(pix_valid),
        .pix_out(pix_out),
        .pix_hit(pix_hit),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data appears one cycle after the address.
    always @(posedge clock) rom_q <= rom[rom_addr];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {hit, pixel} for column x given the last completed fetch.
    function automatic logic [8:0] expectPixel(input int x, input bit v);
        int col;
        logic [7:0] p;
        col = (x - mSx) & 1023;
        if (!v || !mValid || col >= W) return 9'd0;
        p = rom[mRow * W + (mMir ? (W - 1 - col) : col)];
        if (p == KEY) return 9'd0;
        return {1'b1, p};
    endfunction

    // Issue a line_start and check the fetch for 'cycles' address cycles (W = complete fetch).
    task automatic applyStimulus(input int ny, input int sy, input int sx, input bit mir, input int cycles);
        int row;
        int busyCount;
        bit m;
        logic [8:0] prevAddr;
`ifdef SPRITE_MIRROR_EN
        m = mir;
`else
        m = 1'b0;
        if (mir) $display("[TB] mirror request ignored in this build");
`endif
        row = (ny - sy) & 1023;
        @(negedge clock);
        prevAddr   = rom_addr;
        line_start = 1'b1;
        next_y     = 10'(ny & 1023);
        spr_y      = 10'(sy & 1023);
        spr_x      = 10'(sx & 1023);
`ifdef SPRITE_MIRROR_EN
        face_left  = m;
`endif
        mValid = 1'b0;
        @(negedge clock);
        line_start = 1'b0;
        if (row >= H) begin
            busyCount = 0;
            for (int k = 0; k < W + 4; k++) begin
                if (busy) busyCount++;
                @(negedge clock);
            end
            checkOutput("idle_busy_cycles", 32'(busyCount), 32'd0);
            checkOutput("idle_rom_addr", 32'(rom_addr), 32'(prevAddr));
            return;
        end
        for (int c = 0; c < W && c < cycles; c++) begin
            if (c > 0) @(negedge clock);
            checkOutput($sformatf("fetch_addr[%0d]", c), 32'(rom_addr),
                        32'(row * W + (m ? (W - 1 - c) : c)));
            checkOutput("fetch_busy", 32'(busy), 32'd1);
        end
        if (cycles < W) return;
        @(negedge clock);
        checkOutput("last_busy", 32'(busy), 32'd1);
        @(negedge clock);
        checkOutput("done_busy", 32'(busy), 32'd0);
        mValid = 1'b1;
        mRow   = row;
        mSx    = sx & 1023;
        mMir   = m;
    endtask

    // Sweep pix_x across one visible line and compare the overlay against the model.
    task automatic sweepLine(input bit randValid);
        logic [8:0] exp;
        int lastX;
        bit lastV;
        lastX = -1;
        lastV = 1'b0;
        for (int x = 0; x <= 640; x++) begin
            @(negedge clock);
            if (lastX >= 0) begin
                exp = expectPixel(lastX, lastV);
                checkOutput($sformatf("pix_hit@%0d", lastX), 32'(pix_hit), 32'(exp[8]));
                checkOutput($sformatf("pix_out@%0d", lastX), 32'(pix_out), 32'(exp[7:0]));
            end
            if (x < 640) begin
                pix_x     = 10'(x);
                pix_valid = randValid ? ($urandom_range(0, 7) != 0) : 1'b1;
                lastX     = x;
                lastV     = pix_valid;
            end else begin
                pix_valid = 1'b0;
            end
        end
    endtask

    initial begin
        int sy, ny, sx;
        bit mr;
        for (int i = 0; i < 512; i++) begin
            rom[i] = ($urandom_range(0, 4) == 0) ? KEY : 8'($urandom_range(1, 255));
        end

        $display("[TB] reset state");
        rst_n = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_pix_hit", 32'(pix_hit), 32'd0);
        checkOutput("reset_pix_out", 32'(pix_out), 32'd0);
        rst_n = 1'b1;

        $display("[TB] basic fetch row 3, overlay at x=200");
        applyStimulus(103, 100, 200, 1'b0, W);
        sweepLine(1'b0);

        $display("[TB] line above sprite: no fetch, no hits");
        applyStimulus(99, 100, 200, 1'b0, W);
        sweepLine(1'b0);

        $display("[TB] sprite clipped at right edge x=630");
        applyStimulus(105, 100, 630, 1'b0, W);
        sweepLine(1'b0);

        $display("[TB] restart mid-fetch");
        applyStimulus(102, 100, 300, 1'b0, 10);
        applyStimulus(117, 100, 300, 1'b0, W);
        sweepLine(1'b0);

        $display("[TB] reset mid-fetch");
        applyStimulus(110, 100, 50, 1'b0, 5);
        #2 rst_n = 1'b0;
        mValid = 1'b0;
        #1;
        checkOutput("midreset_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_pix_hit", 32'(pix_hit), 32'd0);
        checkOutput("midreset_pix_out", 32'(pix_out), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        sweepLine(1'b0);
        applyStimulus(110, 100, 50, 1'b0, W);
        sweepLine(1'b1);

`ifdef SPRITE_MIRROR_EN
        $display("[TB] mirrored fetch row 0");
        applyStimulus(100, 100, 200, 1'b1, W);
        sweepLine(1'b0);
`endif

        $display("[TB] randomized lines");
        for (int n = 0; n < 6; n++) begin
            sy = int'($urandom_range(0, 479));
            ny = sy + int'($urandom_range(0, 25)) - 2;
            sx = int'($urandom_range(0, 639));
            mr = 1'b0;
`ifdef SPRITE_MIRROR_EN
            mr = 1'($urandom_range(0, 1));
`endif
            applyStimulus(ny, sy, sx, mr, W);
            sweepLine(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
